// File: rtl/micro_uart_pkg.sv
// Shared OCP constants, bus widths and serializer state encoding for micro_uart.
package micro_uart_pkg;

   localparam int OCP_ADDR_WIDTH = 32;
   localparam int OCP_DATA_WIDTH = 32;
   localparam int OCP_BEN_WIDTH  = 4;

   typedef enum logic [2:0] {
      OCP_CMD_IDLE  = 3'd0,
      OCP_CMD_WRITE = 3'd1,
      OCP_CMD_READ  = 3'd2
   } ocp_cmd_e;

   typedef enum logic [1:0] {
      OCP_RESP_NULL = 2'd0,
      OCP_RESP_DVA  = 2'd1,
      OCP_RESP_FAIL = 2'd2,
      OCP_RESP_ERR  = 2'd3
   } ocp_resp_e;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/micro_uart_tx_fifo.sv
// Synchronous TX byte FIFO with first-word-fall-through read data.
module micro_uart_tx_fifo
   import micro_uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == {CNT_W{1'b0}});
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];

   // Storage array; no reset since only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/micro_uart.sv
// OCP-slave debug UART: one character register feeding a TX FIFO and an 8N1 serializer.
module micro_uart
   import micro_uart_pkg::*;
#(
   parameter int ADDR_WIDTH = OCP_ADDR_WIDTH,
   parameter int DATA_WIDTH = OCP_DATA_WIDTH,
   parameter int BEN_WIDTH  = OCP_BEN_WIDTH,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 16,
   parameter int SIM_PRINT  = 1
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [ADDR_WIDTH-1:0] i_MAddr,
   input  logic [2:0]            i_MCmd,
   input  logic [DATA_WIDTH-1:0] i_MData,
   input  logic [BEN_WIDTH-1:0]  i_MByteEn,
   output logic                  o_SCmdAccept,
   output logic [DATA_WIDTH-1:0] o_SData,
   output logic [1:0]            o_SResp,
   output logic                  o_tx
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       CHARREG_IDX = 10'h000;
   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_CNT_LSB = 4;

   function automatic logic [DATA_WIDTH-1:0] status_word(input logic empty, input logic full,
                                                         input logic busy, input logic [3:0] cnt);
      logic [DATA_WIDTH-1:0] word;
      word                     = {DATA_WIDTH{1'b0}};
      word[STAT_EMPTY]         = empty;
      word[STAT_FULL]          = full;
      word[STAT_BUSY]          = busy;
      word[STAT_CNT_LSB +: 4]  = cnt;
      return word;
   endfunction

   logic                  w_full, w_empty, w_is_char, w_cmd_wr, w_cmd_rd;
   logic                  w_wr_char, w_taken, w_push, w_pop, w_tick, w_busy;
   logic [CNT_W-1:0]      w_count;
   logic [7:0]            w_fifo_rdata;
   ocp_resp_e             r_sresp;
   logic [DATA_WIDTH-1:0] r_sdata;
   tx_state_e             r_state, w_state_nxt;
   logic [DIV_W-1:0]      r_div, w_div_nxt;
   logic [2:0]            r_bit, w_bit_nxt;
   logic [7:0]            r_shift, w_shift_nxt;
   logic                  r_tx, w_tx_nxt;
   logic                  w_unused;

   assign w_is_char    = (i_MAddr[11:2] == CHARREG_IDX);
   assign w_cmd_wr     = (i_MCmd == OCP_CMD_WRITE);
   assign w_cmd_rd     = (i_MCmd == OCP_CMD_READ);
   assign w_wr_char    = w_cmd_wr & w_is_char & i_MByteEn[0];
   assign o_SCmdAccept = ~(w_wr_char & w_full);
   assign w_taken      = (w_cmd_wr | w_cmd_rd) & o_SCmdAccept;
   assign w_push       = w_wr_char & ~w_full;
   assign w_busy       = (r_state != TX_IDLE);
   assign w_tick       = (r_div == DIV_LAST);
   assign o_SResp      = r_sresp;
   assign o_SData      = r_sdata;
   assign o_tx         = r_tx;
   assign w_unused     = ^{i_MAddr[ADDR_WIDTH-1:12], i_MAddr[1:0],
                           i_MData[DATA_WIDTH-1:8], i_MByteEn[BEN_WIDTH-1:1]};

   micro_uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (i_MData[7:0]),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // One-cycle OCP response; status is captured at the accept edge.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_sresp <= OCP_RESP_NULL;
         r_sdata <= {DATA_WIDTH{1'b0}};
      end else if (!w_taken) begin
         r_sresp <= OCP_RESP_NULL;
         r_sdata <= {DATA_WIDTH{1'b0}};
      end else if (!w_is_char) begin
         r_sresp <= OCP_RESP_ERR;
         r_sdata <= {DATA_WIDTH{1'b0}};
      end else if (w_cmd_rd) begin
         r_sresp <= OCP_RESP_DVA;
         r_sdata <= status_word(w_empty, w_full, w_busy, 4'(w_count));
      end else begin
         r_sresp <= OCP_RESP_DVA;
         r_sdata <= {DATA_WIDTH{1'b0}};
      end
   end

   // Serializer state register.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_state <= TX_IDLE;
         r_div   <= {DIV_W{1'b0}};
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // Serializer next state: each state or data bit lasts CLK_DIV clocks.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = w_tick ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      case (r_state)
         TX_IDLE: begin
            w_div_nxt = {DIV_W{1'b0}};
            if (!w_empty) begin
               w_state_nxt = TX_START;
               w_shift_nxt = w_fifo_rdata;
            end else begin
               w_state_nxt = TX_IDLE;
            end
         end
         TX_START: begin
            if (w_tick) begin
               w_state_nxt = TX_DATA;
               w_bit_nxt   = 3'd0;
            end else begin
               w_state_nxt = TX_START;
            end
         end
         TX_DATA: begin
            if (w_tick) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_bit_nxt   = r_bit + 3'd1;
               w_state_nxt = (r_bit == 3'd7) ? TX_STOP : TX_DATA;
            end else begin
               w_state_nxt = TX_DATA;
            end
         end
         TX_STOP: begin
            if (w_tick) begin
               w_state_nxt = TX_IDLE;
            end else begin
               w_state_nxt = TX_STOP;
            end
         end
         default: begin
            w_state_nxt = TX_IDLE;
            w_div_nxt   = {DIV_W{1'b0}};
         end
      endcase
   end

   // Serializer outputs; the line level is registered from the next state.
   always_comb begin
      w_pop = (r_state == TX_IDLE) & ~w_empty;
      case (w_state_nxt)
         TX_START: w_tx_nxt = 1'b0;
         TX_DATA:  w_tx_nxt = w_shift_nxt[0];
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   generate
      if (SIM_PRINT != 0) begin : g_sim_print
`ifndef SYNTHESIS
         // Console echo of every accepted character.
         always_ff @(posedge clk) begin
            if (w_push && !nrst) begin
               $write("%c", i_MData[7:0]);
            end
         end
`endif
      end
   endgenerate

endmodule

// File: tb/tb_micro_uart.sv
// Self-checking bench: frame-level model checked every cycle plus directed literal checks.
module tb_micro_uart;

   localparam int CLK_DIV = 16;
   localparam int DEPTH   = 8;
   localparam int FRAME   = 10 * CLK_DIV;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic [31:0] i_MAddr = 32'd0;
   logic [2:0]  i_MCmd = 3'd0;
   logic [31:0] i_MData = 32'd0;
   logic [3:0]  i_MByteEn = 4'd0;
   logic        o_SCmdAccept;
   logic [31:0] o_SData;
   logic [1:0]  o_SResp;
   logic        o_tx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   micro_uart #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4),
      .FIFO_DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .SIM_PRINT(1)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .i_MAddr      (i_MAddr),
      .i_MCmd       (i_MCmd),
      .i_MData      (i_MData),
      .i_MByteEn    (i_MByteEn),
      .o_SCmdAccept (o_SCmdAccept),
      .o_SData      (o_SData),
      .o_SResp      (o_SResp),
      .o_tx         (o_tx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: queue of pending bytes, current frame as 10 line bits.
   logic [7:0]  m_q[$];
   bit          m_send = 1'b0;
   logic [9:0]  m_frame = 10'h3FF;
   int          m_t = 0;
   logic [1:0]  m_resp = 2'd0;
   logic [31:0] m_sdata = 32'd0;
   logic        m_tx, m_char, m_wr, m_rd, m_acc, m_full, m_empty;
   logic [31:0] m_status;

   initial begin
      forever begin
         @(negedge clk);
         if (nrst) begin
            m_q.delete();
            m_send  = 1'b0;
            m_t     = 0;
            m_resp  = 2'd0;
            m_sdata = 32'd0;
         end
         m_tx    = m_send ? m_frame[m_t / CLK_DIV] : 1'b1;
         m_char  = (i_MAddr[11:2] == 10'd0);
         m_wr    = (i_MCmd == 3'd1);
         m_rd    = (i_MCmd == 3'd2);
         m_full  = (m_q.size() == DEPTH);
         m_empty = (m_q.size() == 0);
         m_acc   = !(m_wr && m_char && i_MByteEn[0] && m_full);
         chk("cyc_sresp", 32'(o_SResp), 32'(m_resp));
         chk("cyc_sdata", o_SData, m_sdata);
         chk("cyc_tx", 32'(o_tx), 32'(m_tx));
         chk("cyc_accept", 32'(o_SCmdAccept), 32'(m_acc));
         if (!nrst) begin
            m_status = {24'd0, 4'(m_q.size()), 1'b0, m_send, m_full, m_empty};
            if (!((m_wr || m_rd) && m_acc)) begin
               m_resp = 2'd0; m_sdata = 32'd0;
            end else if (!m_char) begin
               m_resp = 2'd3; m_sdata = 32'd0;
            end else if (m_rd) begin
               m_resp = 2'd1; m_sdata = m_status;
            end else begin
               m_resp = 2'd1; m_sdata = 32'd0;
            end
            if (m_send) begin
               m_t++;
               if (m_t == FRAME) m_send = 1'b0;
            end else if (!m_empty) begin
               m_frame = {1'b1, m_q.pop_front(), 1'b0};
               m_send  = 1'b1;
               m_t     = 0;
            end
            if (m_wr && m_char && i_MByteEn[0] && m_acc) m_q.push_back(i_MData[7:0]);
         end
      end
   end

   // Independent line receiver: samples mid-bit and collects received bytes.
   logic [7:0] rx_q[$];
   bit         rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [9:0] rx_bits = 10'd0;

   initial begin
      forever begin
         @(negedge clk);
         if (nrst) begin
            rx_act = 1'b0;
         end else if (!rx_act) begin
            if (o_tx == 1'b0) begin
               rx_act = 1'b1;
               rx_cnt = 0;
            end
         end else begin
            rx_cnt++;
         end
         if (rx_act && !nrst && (rx_cnt % CLK_DIV) == CLK_DIV / 2) begin
            rx_bits[rx_cnt / CLK_DIV] = o_tx;
            if (rx_cnt / CLK_DIV == 9) begin
               rx_act = 1'b0;
               rx_q.push_back(rx_bits[8:1]);
            end
         end
      end
   end

   task automatic do_cmd(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output int tries);
      tries     = 0;
      i_MCmd    = c;
      i_MAddr   = a;
      i_MData   = d;
      i_MByteEn = b;
      @(negedge clk);
      while (o_SCmdAccept !== 1'b1 && tries < 400) begin
         tries++;
         @(negedge clk);
      end
      chk("cmd_accept", 32'(o_SCmdAccept), 32'd1);
      @(posedge clk);
      #2;
      i_MCmd = 3'd0;
   endtask

   task automatic wait_rx(input int n);
      int c;
      c = 0;
      while (rx_q.size() < n && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("rx_count", 32'(rx_q.size()), 32'(n));
   endtask

   logic [7:0] hello [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

   initial begin
      int tries;
      int c;
      repeat (10) @(posedge clk);
      #2 nrst = 1'b0;
      @(negedge clk);
      chk("rst_tx", 32'(o_tx), 32'd1);
      chk("rst_sresp", 32'(o_SResp), 32'd0);
      chk("rst_accept", 32'(o_SCmdAccept), 32'd1);
      @(posedge clk);
      #2;

      do_cmd(3'd2, 32'h0, 32'h0, 4'hF, tries);
      chk("rd0_resp", 32'(o_SResp), 32'd1);
      chk("rd0_data", o_SData, 32'h0000_0001);
      @(posedge clk);
      #2;
      chk("rd0_null", 32'(o_SResp), 32'd0);
      chk("rd0_zero", o_SData, 32'd0);

      for (int i = 0; i < 6; i++) begin
         do_cmd(3'd1, 32'h0, {24'hA5A5A5, hello[i]}, 4'hF, tries);
         chk("hello_resp", 32'(o_SResp), 32'd1);
      end
      wait_rx(6);
      for (int i = 0; i < 6; i++) begin
         chk("hello_rx", 32'(rx_q[i]), 32'(hello[i]));
      end
      repeat (20) @(posedge clk);
      #2;

      do_cmd(3'd2, 32'h4, 32'h0, 4'hF, tries);
      chk("err_rd_resp", 32'(o_SResp), 32'd3);
      chk("err_rd_data", o_SData, 32'd0);
      do_cmd(3'd1, 32'h4, 32'h78, 4'hF, tries);
      chk("err_wr_resp", 32'(o_SResp), 32'd3);
      do_cmd(3'd1, 32'h0, 32'h7A, 4'hE, tries);
      chk("noben_resp", 32'(o_SResp), 32'd1);
      do_cmd(3'd2, 32'h0, 32'h0, 4'hF, tries);
      chk("unchanged_status", o_SData, 32'h0000_0001);

      do_cmd(3'd1, 32'h0, 32'h61, 4'hF, tries);
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < 8; i++) begin
         do_cmd(3'd1, 32'h0, 32'h30 + 32'(i), 4'hF, tries);
      end
      do_cmd(3'd2, 32'h0, 32'h0, 4'hF, tries);
      chk("full_status", o_SData, 32'h0000_0086);
      do_cmd(3'd1, 32'h0, 32'h0A, 4'hF, tries);
      chk("full_refused_long", 32'(tries >= CLK_DIV), 32'd1);
      chk("full_late_resp", 32'(o_SResp), 32'd1);

      c = 0;
      @(negedge clk);
      while (o_tx !== 1'b0 && c < 400) begin
         @(negedge clk);
         c++;
      end
      chk("mid_frame_seen", 32'(o_tx), 32'd0);
      @(posedge clk);
      #2 nrst = 1'b1;
      #1 chk("mid_rst_tx", 32'(o_tx), 32'd1);
      repeat (3) @(posedge clk);
      #2 nrst = 1'b0;
      do_cmd(3'd2, 32'h0, 32'h0, 4'hF, tries);
      chk("post_rst_status", o_SData, 32'h0000_0001);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
